bnn_frame_ctrl: RTL and testbench

Sequential front/back-end for the combinational BNN `top` (8×8 binary image in, ten signed 5-bit class scores out). It accepts one image row per valid/ready handshake and presents the assembled image on `img_o`. It waits a fixed settle time, snapshots `score_i`, and runs a one-class-per-cycle argmax. It returns the winning class and score over a valid/ready result port, replacing the testbench-driven stimulus path with a hardware responder.

---
 rtl/bnn_io_pkg.sv | 25 ++
 rtl/bnn_frame_ctrl_if.sv | 38 +++
 rtl/bnn_argmax_scan.sv | 69 ++++++
 rtl/bnn_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_bnn_frame_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_io_pkg.sv
// Shared constants, types and FSM states for the BNN frame controller.
// Default geometry: 8x8 binary image, ten signed 5-bit class scores.
package bnn_io_pkg;

   localparam int ROWS          = 8;
   localparam int COLS          = 8;
   localparam int CLASSES       = 10;
   localparam int SCORE_W       = 5;
   localparam int SETTLE_CYCLES = 2;
   localparam int CLS_W         = $clog2(CLASSES);

   typedef logic signed [SCORE_W-1:0] score_t;

   typedef logic [0:0][ROWS-1:0][COLS-1:0] img_t;

   typedef logic [CLASSES-1:0][SCORE_W-1:0] scores_t;

   typedef enum logic [1:0] {
      LOAD,
      SETTLE,
      SCAN,
      DONE
   } state_e;

endpackage

// File: rtl/bnn_frame_ctrl_if.sv
// Row-in and result-out valid/ready channels of the frame controller.
// master: image source / result sink.  slave: the controller itself.
interface bnn_frame_ctrl_if #(
   parameter int COLS    = bnn_io_pkg::COLS,
   parameter int CLS_W   = bnn_io_pkg::CLS_W,
   parameter int SCORE_W = bnn_io_pkg::SCORE_W
);

   logic               row_valid;
   logic               row_ready;
   logic [COLS-1:0]    row_data;

   logic               res_valid;
   logic               res_ready;
   logic [CLS_W-1:0]   res_class;
   logic [SCORE_W-1:0] res_score;

   modport master (
      output row_valid,
      output row_data,
      input  row_ready,
      input  res_valid,
      input  res_class,
      input  res_score,
      output res_ready
   );

   modport slave (
      input  row_valid,
      input  row_data,
      output row_ready,
      output res_valid,
      output res_class,
      output res_score,
      input  res_ready
   );

endinterface

// File: rtl/bnn_argmax_scan.sv
// Sequential argmax, one class per cycle, strict > so ties keep lowest index.
// Ports: clk_i, rst_ni, start_i, scores_i, done_o, class_o, score_o.
module bnn_argmax_scan #(
   parameter int CLASSES = 10,
   parameter int SCORE_W = 5,
   parameter int CLS_W   = $clog2(CLASSES)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic [CLASSES-1:0][SCORE_W-1:0] scores_i,
   output logic                            done_o,
   output logic [CLS_W-1:0]                class_o,
   output logic [SCORE_W-1:0]              score_o
);

   localparam logic [CLS_W-1:0] LAST = CLS_W'(CLASSES - 1);

   logic                      active_q, active_d;
   logic [CLS_W-1:0]          idx_q, idx_d;
   logic signed [SCORE_W-1:0] best_q, best_d;
   logic [CLS_W-1:0]          bidx_q, bidx_d;
   logic signed [SCORE_W-1:0] cand;

   assign cand = scores_i[idx_q];

   always_comb begin
      active_d = active_q;
      idx_d    = idx_q;
      best_d   = best_q;
      bidx_d   = bidx_q;
      done_o   = 1'b0;
      if (start_i) begin
         active_d = 1'b1;
         idx_d    = '0;
      end else if (active_q) begin
         // index 0 seeds the running best unconditionally
         if (idx_q == '0 || cand > best_q) begin
            best_d = cand;
            bidx_d = idx_q;
         end
         if (idx_q == LAST) begin
            active_d = 1'b0;
            idx_d    = '0;
            done_o   = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q <= 1'b0;
         idx_q    <= '0;
         best_q   <= '0;
         bidx_q   <= '0;
      end else begin
         active_q <= active_d;
         idx_q    <= idx_d;
         best_q   <= best_d;
         bidx_q   <= bidx_d;
      end
   end

   assign class_o = bidx_q;
   assign score_o = best_q;

endmodule

// File: rtl/bnn_frame_ctrl.sv
// Frame controller: assembles rows into img_o, settles, snapshots score_i,
// argmaxes it and returns class/score.  Ports: clk_i, rst_ni, bus (slave),
// img_o, score_i, busy_o.
module bnn_frame_ctrl #(
   parameter int ROWS          = 8,
   parameter int COLS          = 8,
   parameter int CLASSES       = 10,
   parameter int SCORE_W       = 5,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   bnn_frame_ctrl_if.slave                  bus,
   output logic [0:0][ROWS-1:0][COLS-1:0]   img_o,
   input  logic [CLASSES-1:0][SCORE_W-1:0]  score_i,
   output logic                             busy_o
);

   import bnn_io_pkg::*;

   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int CW  = $clog2(CLASSES);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [SW-1:0] LAST_SET = SW'(SETTLE_CYCLES - 1);

   state_e                          state_q, state_d;
   logic [RW-1:0]                   r_q, r_d;
   logic [SW-1:0]                   s_q, s_d;
   logic [0:0][ROWS-1:0][COLS-1:0]  img_q;
   logic [CLASSES-1:0][SCORE_W-1:0] scores_q;

   logic row_hs;
   logic snap;
   logic scan_done;

   assign row_hs = bus.row_valid && (state_q == LOAD);
   // snapshot and scan start share the last settle edge
   assign snap   = (state_q == SETTLE) && (s_q == LAST_SET);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      s_d     = s_q;
      unique case (state_q)
         LOAD: begin
            if (row_hs) begin
               r_d = r_q + 1'b1;
               if (r_q == LAST_ROW) begin
                  state_d = SETTLE;
                  r_d     = '0;
                  s_d     = '0;
               end
            end
         end
         SETTLE: begin
            if (s_q == LAST_SET) begin
               state_d = SCAN;
               s_d     = '0;
            end else begin
               s_d = s_q + 1'b1;
            end
         end
         SCAN: begin
            if (scan_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               state_d = LOAD;
               r_d     = '0;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= LOAD;
         r_q      <= '0;
         s_q      <= '0;
         img_q    <= '0;
         scores_q <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         s_q     <= s_d;
         // first row lands in the MSB row
         if (row_hs) begin
            img_q[0][LAST_ROW - r_q] <= bus.row_data;
         end
         if (snap) begin
            scores_q <= score_i;
         end
      end
   end

   bnn_argmax_scan #(
      .CLASSES (CLASSES),
      .SCORE_W (SCORE_W),
      .CLS_W   (CW)
   ) u_scan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (snap),
      .scores_i (scores_q),
      .done_o   (scan_done),
      .class_o  (bus.res_class),
      .score_o  (bus.res_score)
   );

   assign img_o         = img_q;
   assign bus.row_ready = (state_q == LOAD);
   assign bus.res_valid = (state_q == DONE);
   assign busy_o        = (state_q != LOAD);

endmodule

// File: tb/tb_bnn_frame_ctrl.sv
// Directed bench for bnn_frame_ctrl with hand-computed expectations.
// Covers reset, latency, ties, gaps, hold, mid-scan reset, back-to-back.
module tb_bnn_frame_ctrl;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [0:0][7:0][7:0] img;
   logic [9:0][4:0]   score;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   bnn_frame_ctrl_if bus ();

   bnn_frame_ctrl dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .bus     (bus),
      .img_o   (img),
      .score_i (score),
      .busy_o  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] s5(input int v);
      return 5'(v);
   endfunction

   function automatic logic [49:0] pack(input int v [10]);
      logic [49:0] p;
      p = '0;
      for (int c = 0; c < 10; c++) begin
         p[c*5 +: 5] = s5(v[c]);
      end
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_img(input logic [7:0] r [8], input bit gap);
      for (int k = 0; k < 8; k++) begin
         bus.row_valid = 1'b1;
         bus.row_data  = r[k];
         tick();
         bus.row_valid = 1'b0;
         if (gap && k < 7) tick();
      end
   endtask

   task automatic wait_res(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (!bus.res_valid && n < 40) begin
         tick();
         n++;
      end
      chk(tag, n, exp_lat);
   endtask

   task automatic ack();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   logic [7:0] a1 [8];
   logic [7:0] a2 [8];
   logic [7:0] b1 [8];
   logic [7:0] b2 [8];

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      a1 = '{8'h00, 8'h00, 8'h44, 8'h2C, 8'h3C, 8'h04, 8'h04, 8'h00};
      a2 = '{8'h18, 8'h24, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h42, 8'h00};
      b1 = '{8'h00, 8'h78, 8'h04, 8'h1C, 8'h24, 8'h1C, 8'h00, 8'h00};
      b2 = '{8'h00, 8'h08, 8'h18, 8'h08, 8'h08, 8'h08, 8'h1C, 8'h00};

      rst_n         = 1'b0;
      bus.row_valid = 1'b0;
      bus.row_data  = '0;
      bus.res_ready = 1'b0;
      score         = '0;
      #12;
      chk("rst_row_ready", 32'(bus.row_ready), 1);
      chk("rst_img_zero", 32'(img == '0), 1);
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_class", 32'(bus.res_class), 0);
      chk("rst_score", 32'(bus.res_score), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1/2: back-to-back rows, main argmax, latency
      score = pack('{-3, 2, 7, -16, 15, 0, 1, 7, -1, 4});
      load_img(a1, 1'b0);
      chk("t1_ready_low", 32'(bus.row_ready), 0);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_row7", 32'(img[0][7]), 32'h00);
      chk("t1_row5", 32'(img[0][5]), 32'h44);
      chk("t1_row4", 32'(img[0][4]), 32'h2C);
      chk("t1_row3", 32'(img[0][3]), 32'h3C);
      chk("t1_row0", 32'(img[0][0]), 32'h00);
      wait_res("t2_latency", 12);
      chk("t2_class", 32'(bus.res_class), 4);
      chk("t2_score", 32'(bus.res_score), 32'(s5(15)));
      ack();
      chk("t2_valid_clr", 32'(bus.res_valid), 0);
      chk("t2_ready_back", 32'(bus.row_ready), 1);
      chk("t2_busy_clr", 32'(busy), 0);

      // 3a: all minimum
      score = pack('{-16, -16, -16, -16, -16, -16, -16, -16, -16, -16});
      load_img(a1, 1'b0);
      wait_res("t3a_latency", 12);
      chk("t3a_class", 32'(bus.res_class), 0);
      chk("t3a_score", 32'(bus.res_score), 32'(s5(-16)));
      ack();

      // 3b: tie between 2 and 7
      score = pack('{1, 3, 9, -5, 8, 0, -16, 9, 2, 7});
      load_img(a1, 1'b0);
      wait_res("t3b_latency", 12);
      chk("t3b_class", 32'(bus.res_class), 2);
      chk("t3b_score", 32'(bus.res_score), 32'(s5(9)));
      ack();

      // 4: gapped rows, score change after snapshot, held result
      score = pack('{0, -1, -2, 5, 5, 3, 12, 11, -16, -7});
      load_img(a2, 1'b1);
      tick();
      tick();
      score = pack('{15, 15, 15, 15, 15, 15, 15, 15, 15, 15});
      wait_res("t4_latency", 10);
      chk("t4_row7", 32'(img[0][7]), 32'h18);
      chk("t4_row4", 32'(img[0][4]), 32'h7E);
      chk("t4_row0", 32'(img[0][0]), 32'h00);
      bus.row_valid = 1'b1;
      bus.row_data  = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4_hold_valid%0d", i), 32'(bus.res_valid), 1);
         chk($sformatf("t4_hold_class%0d", i), 32'(bus.res_class), 6);
         chk($sformatf("t4_hold_score%0d", i), 32'(bus.res_score),
             32'(s5(12)));
         chk($sformatf("t4_hold_rdy%0d", i), 32'(bus.row_ready), 0);
         tick();
      end
      chk("t4_done_ignore_row", 32'(img[0][7]), 32'h18);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("t4_valid_clr", 32'(bus.res_valid), 0);
      chk("t4_no_row_on_ack", 32'(img[0][7]), 32'h18);
      bus.row_valid = 1'b0;

      // 5: reset during SCAN
      score = pack('{-3, 2, 7, -16, 15, 0, 1, 7, -1, 4});
      load_img(a1, 1'b0);
      repeat (5) tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", 32'(bus.row_ready), 1);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_valid", 32'(bus.res_valid), 0);
      chk("t5_rst_class", 32'(bus.res_class), 0);
      chk("t5_rst_score", 32'(bus.res_score), 0);
      chk("t5_rst_img", 32'(img == '0), 1);
      rst_n = 1'b1;
      tick();
      score = pack('{-1, -2, -3, -4, -5, -6, -7, -8, -9, 3});
      load_img(a2, 1'b0);
      wait_res("t5_latency", 12);
      chk("t5_class", 32'(bus.res_class), 9);
      chk("t5_score", 32'(bus.res_score), 32'(s5(3)));
      chk("t5_row4", 32'(img[0][4]), 32'h7E);
      ack();

      // 6: two images with res_ready held high
      bus.res_ready = 1'b1;
      score = pack('{-3, 2, 7, -16, 15, 0, 1, 7, -1, 4});
      load_img(b1, 1'b0);
      wait_res("t6a_latency", 12);
      chk("t6a_class", 32'(bus.res_class), 4);
      tick();
      chk("t6a_pulse", 32'(bus.res_valid), 0);
      chk("t6a_ready", 32'(bus.row_ready), 1);
      score = pack('{1, 3, 9, -5, 8, 0, -16, 9, 2, 7});
      load_img(b2, 1'b0);
      wait_res("t6b_latency", 12);
      chk("t6b_class", 32'(bus.res_class), 2);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t6b_row%0d", 7 - k), 32'(img[0][7-k]), 32'(b2[k]));
      end
      tick();
      chk("t6b_pulse", 32'(bus.res_valid), 0);
      bus.res_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
